// File: rtl/mem_pkg.sv
// Shared definitions for mem_responder: RV32I load/store size codes, FSM state
// encoding and the store byte-enable helper.
package mem_pkg;

  localparam logic [2:0] SizeB  = 3'b000;
  localparam logic [2:0] SizeH  = 3'b001;
  localparam logic [2:0] SizeW  = 3'b010;
  localparam logic [2:0] SizeBu = 3'b100;
  localparam logic [2:0] SizeHu = 3'b101;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  // lo is the already-aligned byte offset of the access within the word.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      SizeB, SizeBu: be = 4'b0001 << lo;
      SizeH, SizeHu: be = lo[1] ? 4'b1100 : 4'b0011;
      default:       be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage for mem_responder: byte-enabled synchronous write, combinational
// read, no reset so contents survive a responder reset.
module mem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned ADDR_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-stated RV32I data-memory responder backed by mem_array.
// Define MEM_RESPONDER_ALIGN_ERR_EN to fault misaligned or illegal-size accesses.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AddrW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit          NoWait = (WAIT_CYCLES == 0);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  size_q;
  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

  // Without wait states the access happens on the acceptance edge from live inputs.
  logic        acc_we, access;
  logic [31:0] acc_addr, acc_wdata;
  logic [2:0]  acc_size;
  assign acc_we    = NoWait ? req_we    : we_q;
  assign acc_addr  = NoWait ? req_addr  : addr_q;
  assign acc_size  = NoWait ? req_size  : size_q;
  assign acc_wdata = NoWait ? req_wdata : wdata_q;
  assign access    = NoWait ? (state_q == StIdle && req_valid) : (state_q == StWait && cnt_q == 4'd1);

  logic [2:0]       eff_size;
  logic [1:0]       lo;
  logic             acc_err;
  logic [3:0]       be;
  logic [31:0]      lane_wdata, word, shifted, load_data;
  logic [AddrW-1:0] word_idx;

  assign word_idx = AddrW'(acc_addr[31:2] % 30'(DEPTH_WORDS));

  always_comb begin
    eff_size = acc_size;
    acc_err  = 1'b0;
    if (!(acc_size inside {SizeB, SizeH, SizeW, SizeBu, SizeHu})) begin
      eff_size = SizeW;
`ifdef MEM_RESPONDER_ALIGN_ERR_EN
      acc_err  = 1'b1;
`endif
    end
`ifdef MEM_RESPONDER_ALIGN_ERR_EN
    if ((eff_size == SizeH || eff_size == SizeHu) && acc_addr[0]) acc_err = 1'b1;
    if (eff_size == SizeW && acc_addr[1:0] != 2'b00) acc_err = 1'b1;
`endif
    // Forced alignment: drop offset bits finer than the access size.
    case (eff_size)
      SizeB, SizeBu: lo = acc_addr[1:0];
      SizeH, SizeHu: lo = {acc_addr[1], 1'b0};
      default:       lo = 2'b00;
    endcase
    be = byte_en(eff_size, lo);
    case (eff_size)
      SizeB, SizeBu: lane_wdata = {4{acc_wdata[7:0]}};
      SizeH, SizeHu: lane_wdata = {2{acc_wdata[15:0]}};
      default:       lane_wdata = acc_wdata;
    endcase
    shifted = word >> {lo, 3'b000};
    case (eff_size)
      SizeB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      SizeBu:  load_data = {24'd0, shifted[7:0]};
      SizeH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      SizeHu:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
    if (acc_we || acc_err) load_data = 32'd0;
  end

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (AddrW)
  ) u_mem (
    .clk  (clk),
    .we   (access && acc_we && !acc_err),
    .be   (be),
    .addr (word_idx),
    .wdata(lane_wdata),
    .rdata(word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      size_q      <= 3'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata;
            if (NoWait) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= load_data;
              rsp_err_q   <= acc_err;
            end else begin
              state_q <= StWait;
              cnt_q   <= 4'(WAIT_CYCLES);
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            state_q     <= StResp;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_data;
            rsp_err_q   <= acc_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
